// File: rtl/hazard_sequencer.sv
// Front-end hazard sequencer: load-use stall, LDM immediate slot, flush and memory-busy freeze.
// Outputs are combinational from state and inputs; only state and stall_cnt are registered.
module hazard_sequencer #(
  parameter logic [5:0] LDM_OP = 6'b111111,
  parameter logic [5:0] NOT_OP = 6'b000100,
  parameter logic [5:0] ADD_OP = 6'b001011,
  parameter logic [5:0] STD_OP = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [2:0] rs_addr,
  input  logic [2:0] rt_addr,
  input  logic [2:0] ex_rd_addr,
  input  logic       ex_mem_read,
  input  logic       flush_req,
  input  logic       mem_busy,
  input  logic       cnt_clr,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       imm_sel,
  output logic [1:0] state,
  output logic [7:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IMM   = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       uses_rs, uses_rt, hazard, stall_take;

  assign uses_rs = (opcode == NOT_OP) || (opcode == ADD_OP) || (opcode == STD_OP);
  assign uses_rt = (opcode == ADD_OP) || (opcode == STD_OP);
  assign hazard  = ex_mem_read &&
                   ((uses_rs && (rs_addr == ex_rd_addr)) || (uses_rt && (rt_addr == ex_rd_addr)));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    imm_sel     = 1'b0;
    state_d     = state_q;
    stall_take  = 1'b0;
    if (rst) begin
      // Reset outputs hold the front end with a NOP in flight, independent of the clock.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (flush_req) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pc_en       = !mem_busy;
      state_d     = RUN;
    end else if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = STALL;
            stall_take  = 1'b1;
          end else if (opcode == LDM_OP) begin
            state_d = IMM;
          end
        end
        STALL: state_d = RUN;
        IMM: begin
          imm_sel     = 1'b1;
          idex_bubble = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = 8'h00;
    end else if (stall_take && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: per-cycle reference model feeding an expected-value queue.
module tb_hazard_sequencer;

  localparam logic [5:0] LDM = 6'b111111;
  localparam logic [5:0] NOTO = 6'b000100;
  localparam logic [5:0] ADD = 6'b001011;
  localparam logic [5:0] STD = 6'b000010;
  localparam logic [5:0] NOP = 6'b000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [2:0] rs_addr, rt_addr, ex_rd_addr;
  logic       ex_mem_read, flush_req, mem_busy, cnt_clr;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, imm_sel;
  logic [1:0] state;
  logic [7:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [1:0] m_state = 2'b00;
  logic [7:0] m_cnt   = 8'h00;
  logic [1:0] m_next;
  logic       m_inc;

  hazard_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .flush_req(flush_req),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .imm_sel(imm_sel),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic emr, input logic fl,
                       input logic mb, input logic clr);
    opcode = op; rs_addr = rs; rt_addr = rt; ex_rd_addr = rd;
    ex_mem_read = emr; flush_req = fl; mem_busy = mb; cnt_clr = clr;
  endtask

  // Expected outputs for the current inputs and model state; also records the model's next step.
  function automatic logic [14:0] expect_out();
    logic pc, ie, fl, bub, imm, urs, urt, hz;
    urs = (opcode == NOTO) || (opcode == ADD) || (opcode == STD);
    urt = (opcode == ADD) || (opcode == STD);
    hz  = ex_mem_read && ((urs && rs_addr == ex_rd_addr) || (urt && rt_addr == ex_rd_addr));
    m_inc = 1'b0;
    m_next = m_state;
    if (rst) begin
      m_next = 2'b00;
      return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00};
    end
    {pc, ie, fl, bub, imm} = 5'b11000;
    if (flush_req) begin
      fl = 1'b1; bub = 1'b1; pc = !mem_busy; m_next = 2'b00;
    end else if (mem_busy) begin
      pc = 1'b0; ie = 1'b0;
    end else if (m_state == 2'b00) begin
      if (hz) begin
        pc = 1'b0; ie = 1'b0; bub = 1'b1; m_next = 2'b10; m_inc = 1'b1;
      end else if (opcode == LDM) begin
        m_next = 2'b01;
      end
    end else if (m_state == 2'b01) begin
      imm = 1'b1; bub = 1'b1; m_next = 2'b00;
    end else begin
      m_next = 2'b00;
    end
    return {pc, ie, fl, bub, imm, m_state, m_cnt};
  endfunction

  // One clock cycle: inputs already driven just after a rising edge.
  task automatic cyc(input string tag);
    exp_t e;
    e.tag = tag;
    e.val = expect_out();
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val(e.tag, {17'd0, pc_en, ifid_en, ifid_flush, idex_bubble, imm_sel, state, stall_cnt},
              {17'd0, e.val});
    @(posedge clk);
    if (rst) begin
      m_state = 2'b00; m_cnt = 8'h00;
    end else begin
      m_state = m_next;
      if (cnt_clr) m_cnt = 8'h00;
      else if (m_inc && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    cyc("reset");
    cyc("reset_hold");
    rst = 1'b0;
    drive(NOP, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle_run");

    // Load-use hazard on rs: one bubble then RUN
    drive(ADD, 3'd3, 3'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("hz_rs");
    check_val("hz_state_stall", {30'd0, state}, 32'd2);
    cyc("hz_stall_ignored");
    check_val("hz_cnt_one", {24'd0, stall_cnt}, 32'd1);
    // rt match only, and NOT which ignores rt
    drive(STD, 3'd0, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("hz_rt");
    drive(NOP, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("hz_rt_stall");
    drive(NOTO, 3'd1, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("not_no_rt");
    drive(ADD, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("no_memread");

    // LDM: matching addresses never form a hazard
    drive(LDM, 3'd3, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("ldm_run");
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ldm_imm");
    cyc("ldm_back");
    check_val("ldm_imm_off", {31'd0, imm_sel}, 32'd0);

    // Flush beats hazard; counter untouched
    drive(ADD, 3'd2, 3'd4, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("flush_hz");
    check_val("flush_state_run", {30'd0, state}, 32'd0);
    // Flush with mem_busy drops pc_en
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("flush_busy");

    // IMM frozen by mem_busy for three cycles, then imm_sel for one cycle
    drive(LDM, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ldm2");
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("imm_busy");
    mem_busy = 1'b0;
    cyc("imm_release");
    cyc("imm_done");
    // Flush in IMM cancels the immediate slot
    drive(LDM, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ldm3");
    flush_req = 1'b1;
    cyc("imm_flush");
    flush_req = 1'b0; opcode = NOP;
    cyc("after_imm_flush");

    // Saturation of stall_cnt
    for (int i = 0; i < 260; i++) begin
      drive(ADD, 3'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("sat_hz");
      drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("sat_stall");
    end
    check_val("sat_ff", {24'd0, stall_cnt}, 32'hFF);
    drive(ADD, 3'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("clr_with_hz");
    check_val("clr_zero", {24'd0, stall_cnt}, 32'd0);
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("clr_stall");

    // Asynchronous reset in the middle of STALL
    drive(STD, 3'd4, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("pre_arst");
    check_val("arst_in_stall", {30'd0, state}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check_val("arst_outs", {27'd0, pc_en, ifid_en, ifid_flush, idex_bubble, imm_sel}, 32'b00110);
    check_val("arst_state", {22'd0, state, stall_cnt}, 32'd0);
    m_state = 2'b00; m_cnt = 8'h00;
    @(posedge clk); #1;
    cyc("arst_hold");
    rst = 1'b0;
    drive(NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("arst_release");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] ops [5];
      ops = '{NOP, LDM, NOTO, ADD, STD};
      rst = ($urandom_range(0, 59) == 0);
      drive(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL provide parameter LDM_OP, default 6'b111111, opcode of two-word load-immediate.
REQ-002 SHALL provide parameters NOT_OP=6'b000100, ADD_OP=6'b001011, STD_OP=6'b000010, opcodes reading source registers.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port opcode  input  6  opcode of instruction in IF/ID.
REQ-006 SHALL provide port rs_addr  input  3  IF/ID source register 1.
REQ-007 SHALL provide port rt_addr  input  3  IF/ID source register 2.
REQ-008 SHALL provide port ex_rd_addr  input  3  destination register of instruction in ID/EX.
REQ-009 SHALL provide port ex_mem_read  input  1  ID/EX instruction reads memory (load).
REQ-010 SHALL provide port flush_req  input  1  control-flow redirect; discard IF/ID.
REQ-011 SHALL provide port mem_busy  input  1  memory stage not ready; freeze pipeline front end.
REQ-012 SHALL provide port cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-013 SHALL provide port pc_en  output  1  PC update enable.
REQ-014 SHALL provide port ifid_en  output  1  IF/ID register load enable.
REQ-015 SHALL provide port ifid_flush  output  1  IF/ID cleared to NOP on next edge.
REQ-016 SHALL provide port idex_bubble  output  1  ID/EX loads all-zero control signals.
REQ-017 SHALL provide port imm_sel  output  1  IF/ID word is LDM immediate data; latch into ID/EX immediate field.
REQ-018 SHALL provide port state  output  2  current FSM state: RUN=00, IMM=01, STALL=10.
REQ-019 SHALL provide port stall_cnt  output  8  saturating count of hazard bubble cycles.

Function
REQ-020 SHALL decode uses_rs=1 for NOT_OP, ADD_OP, STD_OP; uses_rt=1 for ADD_OP, STD_OP; both 0 otherwise.
REQ-021 SHALL define hazard = ex_mem_read & ((uses_rs & rs_addr==ex_rd_addr) | (uses_rt & rt_addr==ex_rd_addr)), evaluated combinationally.
REQ-022 SHALL drive outputs combinationally from state and inputs; default pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, imm_sel=0.
REQ-023 RUN: if hazard, SHALL set pc_en=0, ifid_en=0, idex_bubble=1, and go to STALL.
REQ-024 RUN: else if opcode==LDM_OP, SHALL pass LDM with defaults and go to IMM.
REQ-025 RUN: hazard SHALL take priority over LDM detection (an LDM in IF/ID never produces a hazard).
REQ-026 STALL: SHALL drive defaults for exactly one cycle (hazard re-evaluated is ignored) and return to RUN; total load-use penalty is one bubble.
REQ-027 IMM: SHALL set imm_sel=1, idex_bubble=1 (immediate word never decoded as instruction) and return to RUN.
REQ-028 flush_req=1 in any state SHALL force ifid_flush=1, idex_bubble=1, pc_en=1, and next state RUN; it overrides hazard, LDM detection, and IMM (imm_sel=0).
REQ-029 mem_busy=1 (and flush_req=0) SHALL force pc_en=0, ifid_en=0, idex_bubble=0, imm_sel=0; state and stall_cnt SHALL hold.
REQ-030 If flush_req and mem_busy are both 1, flush_req behaviour SHALL apply, except pc_en=0.
REQ-031 stall_cnt SHALL increment by 1 on each edge where the RUN-to-STALL transition is taken, saturating at 8'hFF.
REQ-032 cnt_clr=1 SHALL zero stall_cnt on the next edge, taking priority over increment.
REQ-033 state encoding 11 SHALL be unreachable; if entered, next state SHALL be RUN with default outputs.

Reset
REQ-034 While rst=1: state=RUN, stall_cnt=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, imm_sel=0, regardless of clk.
REQ-035 Reset asserted mid-STALL or mid-IMM SHALL abandon the sequence; first cycle after deassertion SHALL be RUN with defaults.

Verification
REQ-036 ex_mem_read=1, ex_rd_addr=3, opcode=ADD_OP, rs_addr=3 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, state STALL, then RUN; stall_cnt 0->1.
REQ-037 opcode=LDM_OP in RUN -> next cycle state=IMM, imm_sel=1, idex_bubble=1; following cycle RUN, imm_sel=0.
REQ-038 hazard present and flush_req=1 same cycle -> ifid_flush=1, idex_bubble=1, state stays RUN, stall_cnt unchanged.
REQ-039 in IMM, mem_busy=1 for 3 cycles -> state IMM held, pc_en=0, imm_sel=0; after release imm_sel=1 for one cycle.
REQ-040 force 260 hazard stalls -> stall_cnt=8'hFF; cnt_clr=1 together with hazard -> stall_cnt=0.
REQ-041 rst asserted asynchronously during STALL -> outputs take reset values immediately; after release state=RUN, stall_cnt=0.
